aes_stream_ctrl: RTL

- Initiator-side controller that drives the AES pipeline core: issues key loads, feeds plaintext/ciphertext blocks, and collects results into an output FIFO.
- The core's output has no backpressure, so this block credit-limits issue to guarantee every result has a FIFO slot.
- Sits between the bus/DMA stream (valid/ready on both sides) and the AES core.

---
 rtl/aes_stream_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_stream_ctrl.sv
// Credit-limited stream controller for a pipelined AES core, with a first-word fall-through result FIFO.
// Optional issue-to-result latency checker enabled by defining AES_STREAM_LATCHK_EN.
module aes_stream_ctrl #(
  parameter int CORE_LATENCY = 40,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [127:0]                    key_i,
  input  logic                            decrypt_i,
  input  logic                            key_load_i,
  output logic                            key_busy_o,
  input  logic                            s_valid_i,
  output logic                            s_ready_o,
  input  logic [127:0]                    s_data_i,
  output logic                            m_valid_o,
  input  logic                            m_ready_i,
  output logic [127:0]                    m_data_o,
  output logic                            core_rst_o,
  output logic                            core_load_key_o,
  output logic [127:0]                    core_key_o,
  output logic                            core_decrypt_o,
  output logic                            core_indata_valid_o,
  input  logic                            core_indata_ready_i,
  output logic [127:0]                    core_indata_o,
  input  logic [127:0]                    core_outdata_i,
  input  logic                            core_outdata_valid_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] inflight_o,
  output logic                            err_overflow_o,
  output logic                            err_latency_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   LIMIT_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] ONE_A   = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEY_REQ  = 3'd1,
    KEY_WAIT = 3'd2,
    RUN      = 3'd3,
    DRAIN    = 3'd4,
    CORE_RST = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [127:0]    core_key_q, core_key_d;
  logic            core_dec_q, core_dec_d;
  logic [127:0]    pend_key_q, pend_key_d;
  logic            pend_dec_q, pend_dec_d;
  logic            key_busy_q, key_busy_d;
  logic            load_key_q, load_key_d;
  logic            core_rst_q, core_rst_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            err_ovf_q, err_ovf_d;
  logic [127:0]    mem_q [FIFO_DEPTH];

  logic [CW:0]     used_s;
  logic            credit_ok_s;
  logic            run_s;
  logic            accept_s;
  logic            ret_s;
  logic            full_s;
  logic            rd_en_s;
  logic            wr_en_s;

  // Every result needs a FIFO slot, so issue is bounded by in-flight plus stored results.
  assign used_s      = {1'b0, inflight_q} + {1'b0, count_q};
  assign credit_ok_s = (used_s < LIMIT_C);
  assign run_s       = (state_q == RUN);
  assign accept_s    = s_valid_i && s_ready_o;
  assign ret_s       = core_outdata_valid_i && (inflight_q != '0);
  assign full_s      = (count_q == DEPTH_C);
  assign rd_en_s     = (count_q != '0) && m_ready_i;
  assign wr_en_s     = core_outdata_valid_i && (!full_s || rd_en_s);

  assign s_ready_o           = run_s && core_indata_ready_i && credit_ok_s;
  assign core_indata_valid_o = s_valid_i && run_s && credit_ok_s;
  assign core_indata_o       = s_data_i;
  assign m_valid_o           = (count_q != '0);
  assign m_data_o            = mem_q[rd_ptr_q];
  assign key_busy_o          = key_busy_q;
  assign core_load_key_o     = load_key_q;
  assign core_rst_o          = core_rst_q;
  assign core_key_o          = core_key_q;
  assign core_decrypt_o      = core_dec_q;
  assign inflight_o          = inflight_q;
  assign err_overflow_o      = err_ovf_q;

  // Key sequencing FSM; a rekey from RUN is parked until the core is empty.
  always_comb begin
    state_d    = state_q;
    core_key_d = core_key_q;
    core_dec_d = core_dec_q;
    pend_key_d = pend_key_q;
    pend_dec_d = pend_dec_q;
    case (state_q)
      IDLE: begin
        if (key_load_i) begin
          core_key_d = key_i;
          core_dec_d = decrypt_i;
          state_d    = KEY_REQ;
        end
      end
      KEY_REQ:  state_d = KEY_WAIT;
      KEY_WAIT: begin
        if (core_indata_ready_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (key_load_i) begin
          pend_key_d = key_i;
          pend_dec_d = decrypt_i;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight_q == '0) begin
          core_key_d = pend_key_q;
          core_dec_d = pend_dec_q;
          state_d    = CORE_RST;
        end
      end
      CORE_RST: state_d = KEY_REQ;
      default:  state_d = IDLE;
    endcase
    key_busy_d = (state_d != RUN);
    load_key_d = (state_d == KEY_REQ);
    core_rst_d = (state_d == CORE_RST);
  end

  // In-flight counter and result FIFO bookkeeping.
  always_comb begin
    inflight_d = inflight_q;
    count_d    = count_q;
    case ({accept_s, ret_s})
      2'b10:   inflight_d = inflight_q + ONE_C;
      2'b01:   inflight_d = inflight_q - ONE_C;
      default: inflight_d = inflight_q;
    endcase
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    wr_ptr_d  = wr_en_s ? (wr_ptr_q + ONE_A) : wr_ptr_q;
    rd_ptr_d  = rd_en_s ? (rd_ptr_q + ONE_A) : rd_ptr_q;
    err_ovf_d = err_ovf_q || (core_outdata_valid_i && full_s && !rd_en_s);
  end

  // Control and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      core_key_q <= 128'd0;
      core_dec_q <= 1'b0;
      pend_key_q <= 128'd0;
      pend_dec_q <= 1'b0;
      key_busy_q <= 1'b1;
      load_key_q <= 1'b0;
      core_rst_q <= 1'b0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_key_q <= core_key_d;
      core_dec_q <= core_dec_d;
      pend_key_q <= pend_key_d;
      pend_dec_q <= pend_dec_d;
      key_busy_q <= key_busy_d;
      load_key_q <= load_key_d;
      core_rst_q <= core_rst_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // Result storage; contents are meaningless while the count says empty.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= core_outdata_i;
    end
  end

`ifdef AES_STREAM_LATCHK_EN
  logic [CORE_LATENCY-1:0] lat_sr_q, lat_sr_d;
  logic                    err_lat_q, err_lat_d;

  // The oldest accept must line up exactly with the core's result strobe.
  always_comb begin
    lat_sr_d  = (lat_sr_q << 1) | CORE_LATENCY'(accept_s);
    err_lat_d = err_lat_q || (lat_sr_q[CORE_LATENCY-1] != core_outdata_valid_i);
  end

  // Latency checker registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_sr_q  <= '0;
      err_lat_q <= 1'b0;
    end else begin
      lat_sr_q  <= lat_sr_d;
      err_lat_q <= err_lat_d;
    end
  end

  assign err_latency_o = err_lat_q;
`else
  assign err_latency_o = 1'b0;
`endif

endmodule
